// File: rtl/md_pkg.sv
// Shared encodings and defaults for the HI/LO multiply/divide path.
// MDU_MADD_EN enables md_cal=11 as madd/maddu.
package md_pkg;

  typedef enum logic [1:0] {
    MD_CAL_NONE = 2'b00,
    MD_CAL_MULT = 2'b01,
    MD_CAL_DIV  = 2'b10,
    MD_CAL_MADD = 2'b11
  } md_cal_e;

  typedef enum logic [1:0] {
    MD_WR_NONE = 2'b00,
    MD_WR_LO   = 2'b01,
    MD_WR_HI   = 2'b10
  } md_wr_e;

  typedef enum logic [1:0] {
    MD_RD_NONE = 2'b00,
    MD_RD_LO   = 2'b01,
    MD_RD_HI   = 2'b10
  } md_rd_e;

  localparam int unsigned MD_MULT_CYCLES = 5;
  localparam int unsigned MD_DIV_CYCLES  = 10;

  // True when the request launches a multi-cycle operation in this build.
  function automatic logic md_cal_starts(md_cal_e cal);
`ifdef MDU_MADD_EN
    return cal != MD_CAL_NONE;
`else
    return (cal == MD_CAL_MULT) || (cal == MD_CAL_DIV);
`endif
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// E-stage request/response bundle between the decoder side and md_unit.
interface md_unit_if;
  import md_pkg::*;

  md_cal_e     md_cal;
  logic        is_signed;
  md_wr_e      md_wr;
  md_rd_e      md_read;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  modport master (
    output md_cal, is_signed, md_wr, md_read, rs_val, rt_val, flush,
    input  busy, hi, lo, rd_data
  );

  modport slave (
    input  md_cal, is_signed, md_wr, md_read, rs_val, rt_val, flush,
    output busy, hi, lo, rd_data
  );

endinterface

// File: rtl/md_compute.sv
// Combinational 64-bit mult / div / multiply-accumulate datapath.
module md_compute
  import md_pkg::*;
(
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic        is_signed_i,
  input  md_cal_e     op_i,
  input  logic [63:0] hilo_i,
  output logic [63:0] result_o,
  output logic        div_by_zero_o
);

  logic [63:0] rs_ext, rt_ext, product;
  logic        rs_neg, rt_neg;
  logic [31:0] rs_mag, rt_mag, divisor;
  logic [31:0] q_mag, r_mag, quot, rem;

  // Low 64 bits of the product of the extended operands are correct for both signednesses.
  assign rs_ext  = is_signed_i ? {{32{rs_i[31]}}, rs_i} : {32'b0, rs_i};
  assign rt_ext  = is_signed_i ? {{32{rt_i[31]}}, rt_i} : {32'b0, rt_i};
  assign product = rs_ext * rt_ext;

  // Divide on magnitudes so 0x80000000 / -1 cannot overflow the divider.
  assign rs_neg  = is_signed_i & rs_i[31];
  assign rt_neg  = is_signed_i & rt_i[31];
  assign rs_mag  = rs_neg ? (~rs_i + 32'd1) : rs_i;
  assign rt_mag  = rt_neg ? (~rt_i + 32'd1) : rt_i;
  assign divisor = (rt_i == 32'd0) ? 32'd1 : rt_mag;
  assign q_mag   = rs_mag / divisor;
  assign r_mag   = rs_mag % divisor;
  assign quot    = (rs_neg ^ rt_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem     = rs_neg ? (~r_mag + 32'd1) : r_mag;

  assign div_by_zero_o = (op_i == MD_CAL_DIV) && (rt_i == 32'd0);

  always_comb begin
    result_o = '0;
    case (op_i)
      MD_CAL_MULT: result_o = product;
      MD_CAL_DIV:  result_o = {rem, quot};
      MD_CAL_MADD: result_o = hilo_i + product;
      default:     result_o = '0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// HI/LO multiply/divide unit: pending result, busy countdown, commit and read mux.
// MDU_MADD_EN enables madd/maddu on md_cal=11; otherwise that code is ignored.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
  input logic      clk,
  input logic      reset,
  md_unit_if.slave bus
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [63:0]     pend_q, pend_d;
  logic            pend_dbz_q, pend_dbz_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;

  logic        busy, start, wr_ok, dbz;
  logic [63:0] result;

  assign busy  = (cnt_q != '0);
  assign start = md_cal_starts(bus.md_cal) & ~bus.flush & ~busy;
  assign wr_ok = ~bus.flush & ~busy;

  md_compute u_compute (
    .rs_i          (bus.rs_val),
    .rt_i          (bus.rt_val),
    .is_signed_i   (bus.is_signed),
    .op_i          (bus.md_cal),
    .hilo_i        ({hi_q, lo_q}),
    .result_o      (result),
    .div_by_zero_o (dbz)
  );

  always_comb begin
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pend_dbz_d = pend_dbz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    if (start) begin
      cnt_d      = (bus.md_cal == MD_CAL_DIV) ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
      pend_d     = result;
      pend_dbz_d = dbz;
    end else if (busy) begin
      cnt_d = cnt_q - CntW'(1);
      // Divide by zero still spends the full latency but leaves HI/LO alone.
      if (cnt_q == CntW'(1) && !pend_dbz_q) begin
        hi_d = pend_q[63:32];
        lo_d = pend_q[31:0];
      end
    end

    if (wr_ok) begin
      case (bus.md_wr)
        MD_WR_LO: lo_d = bus.rs_val;
        MD_WR_HI: hi_d = bus.rs_val;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q      <= '0;
      pend_q     <= '0;
      pend_dbz_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_dbz_q <= pend_dbz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign bus.busy = busy;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  always_comb begin
    bus.rd_data = '0;
    case (bus.md_read)
      MD_RD_LO: bus.rd_data = lo_q;
      MD_RD_HI: bus.rd_data = hi_q;
      default:  bus.rd_data = '0;
    endcase
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit in the E stage of the MIPS pipeline. It executes the HI/LO requests raised by the instruction decoder: mult/multu/div/divu, mthi/mtlo and mfhi/mflo. It holds the HI and LO architectural registers and models multi-cycle latency with a busy counter, which the hazard unit uses to stall later HI/LO instructions. It must honour the exception flush so that a cancelled instruction never changes HI/LO.

## Interface
- MULT_CYCLES, 5, cycles busy stays high after a mult/multu start (≥1)
- DIV_CYCLES, 10, cycles busy stays high after a div/divu start (≥1)

- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- md_cal  in  2  calculation request: MD_CAL_NONE=00, MD_CAL_MULT=01, MD_CAL_DIV=10, MD_CAL_MADD=11 (only with macro)
- is_signed  in  1  1 = signed mult/div, 0 = unsigned
- md_wr  in  2  direct write: MD_WR_NONE=00, MD_WR_LO=01, MD_WR_HI=10
- md_read  in  2  read select: MD_RD_NONE=00, MD_RD_LO=01, MD_RD_HI=10
- rs_val  in  32  forwarded rs operand, which is the dividend/multiplicand and the mthi/mtlo source
- rt_val  in  32  forwarded rt operand, which is the divisor/multiplier
- flush  in  1  exception/eret cancel of the E-stage instruction this cycle
- busy  out  1  an operation is in flight
- hi  out  32  HI register
- lo  out  32  LO register
- rd_data  out  32  mfhi/mflo result

## Operation
- start = (md_cal != NONE) & !flush & !busy.
- On a start edge:
  - compute the 64-bit result of rs_val op rt_val and hold it in a pending register;
  - load the counter with MULT_CYCLES or DIV_CYCLES;
  - set busy = 1.
- Counter decrements each edge while busy. On the edge where it goes 1→0, commit pending into {hi,lo} and clear busy.
- mult: {hi,lo} = rs×rt, 64-bit; signed or unsigned per is_signed.
- div:
  - lo = quotient, truncated toward zero.
  - hi = remainder, which takes the sign of the dividend.
  - Signed 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - Divide by zero: the full busy period still runs, and HI/LO are left unchanged at commit.
- md_wr, when not flushed and not busy: write rs_val to the selected register at the edge.
- md_wr while busy is dropped, and a start request while busy is dropped. The hazard unit prevents both; the bench flags them with assertions.
- flush blocks only the same-cycle start and md_wr. An operation already in flight always completes.
- rd_data is combinational:
  - md_read=HI gives hi; md_read=LO gives lo; otherwise 0.
  - While busy it shows the old values; the hazard unit stalls mfhi/mflo on (md_cal!=NONE | busy).

## Timing
- Reset (reset=0 at an edge):
  - hi=0, lo=0, busy=0, counter=0, pending discarded.
  - Applies mid-operation too: no later commit occurs.
- busy is high for exactly N cycles after the start edge, where N = MULT_CYCLES or DIV_CYCLES.
- New hi/lo values are visible from the commit edge onward.
- mthi/mtlo latency is one edge.
- A new start is accepted in the cycle after busy falls.
- All state is registered. The only combinational output path is md_read→rd_data.

## Configuration
- MDU_MADD_EN defined: md_cal=11 starts madd/maddu.
  - Result {hi,lo} = {hi,lo} + rs×rt, using the {hi,lo} value at the start edge. Overflow wraps modulo 2^64.
  - Signedness per is_signed; latency MULT_CYCLES.
- MDU_MADD_EN undefined: md_cal=11 is treated as NONE. No start, state unchanged.

## Structure
- Shared package md_pkg holds:
  - the MD_CAL_*, MD_WR_*, MD_RD_* encodings;
  - the default cycle constants.
- The decoder and the hazard unit import these same encodings.
- One sub-module, md_compute: combinational, taking rs, rt, is_signed, op and the current {hi,lo}, producing the 64-bit result and a div_by_zero flag.
- The md_unit top holds the counter, the pending register, the commit logic and the read mux.

## Test plan
- Signed mult, rs=0xFFFFFFFE, rt=3 → busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- Unsigned mult, same operands → hi=0x00000002, lo=0xFFFFFFFA; rd_data follows md_read.
- Signed div, rs=0xFFFFFFF9 (−7), rt=2 → busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. Separately, 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Div by zero after mthi 0x1234 / mtlo 0x5678 → busy 10 cycles; hi=0x1234 and lo=0x5678 unchanged.
- md_cal=MULT with flush=1 → busy stays 0 and HI/LO unchanged. mtlo with flush=1 → lo unchanged. A flush at cycle 3 of a running div does not stop the commit.
- reset low at cycle 4 of a div → next edge busy=0, hi=lo=0, no commit afterward. With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, then madd 1×1 → hi=1, lo=0.
